udp_tx_data_module: RTL and testbench

UDP_TX_DATA_MODULE -- requirements
Module: udp_tx_data_module

---
 rtl/udp_tx_data_module.sv | 199 +++++++++++++++++++
 tb/tb_udp_tx_data_module.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_data_module.sv
// Word FIFO feeding a fixed-length UDP payload byte streamer.
// Words are sent MSB byte first after a request/ack handshake with the TX engine.
module udp_tx_data_module #(
   parameter int DATA_WIDTH    = 72,
   parameter int WORDS_PER_PKT = 16,
   parameter int FIFO_DEPTH    = 32
) (
   input  logic                  DATA_O_CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] DATA_I,
   input  logic                  DATA_I_VLD,
   output logic                  DATA_I_RDY,
   output logic                  TX_REQ,
   output logic [15:0]           TX_LEN,
   input  logic                  TX_ACK,
   input  logic                  TX_BYTE_RD,
   output logic [7:0]            TX_BYTE,
   output logic                  TX_BYTE_VLD,
   output logic                  TX_LAST,
   output logic                  OVERFLOW
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = AW + 1;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int WW    = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

   localparam logic [CW-1:0] LP_DEPTH     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] LP_WPP       = CW'(WORDS_PER_PKT);
   localparam logic [BW-1:0] LP_BYTE_LAST = BW'(BYTES - 1);
   localparam logic [WW-1:0] LP_WORD_LAST = WW'(WORDS_PER_PKT - 1);
   localparam logic [15:0]   LP_LEN       = 16'(WORDS_PER_PKT * BYTES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  r_rdy;
   logic                  r_ovf;
   logic                  r_tx_req;
   logic [15:0]           r_tx_len;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [BW-1:0]         r_byte_idx;
   logic [BW-1:0]         w_byte_idx_nxt;
   logic [WW-1:0]         r_word_idx;
   logic [WW-1:0]         w_word_idx_nxt;
   logic                  r_vld;
   logic                  r_last;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_advance;
   logic                  w_byte_end;
   logic                  w_word_end;

   assign w_push     = DATA_I_VLD & r_rdy;
   assign w_advance  = (r_state == ST_SEND) & TX_BYTE_RD;
   assign w_byte_end = (r_byte_idx == LP_BYTE_LAST);
   assign w_word_end = (r_word_idx == LP_WORD_LAST);
   assign w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);

   assign DATA_I_RDY  = r_rdy;
   assign OVERFLOW    = r_ovf;
   assign TX_REQ      = r_tx_req;
   assign TX_LEN      = r_tx_len;
   assign TX_BYTE     = r_shift[DATA_WIDTH-1 -: 8];
   assign TX_BYTE_VLD = r_vld;
   assign TX_LAST     = r_last;

   // FSM state register
   always_ff @(posedge DATA_O_CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; pops the head word on grant and on each word boundary inside a packet
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_count >= LP_WPP) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (TX_ACK) begin
               w_state_nxt = ST_SEND;
               w_pop       = 1'b1;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_SEND: begin
            if (TX_BYTE_RD && w_byte_end && w_word_end) begin
               w_state_nxt = ST_GAP;
            end else if (TX_BYTE_RD && w_byte_end) begin
               w_state_nxt = ST_SEND;
               w_pop       = 1'b1;
            end else begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte/word position of the byte that will be presented after this edge
   always_comb begin
      w_byte_idx_nxt = r_byte_idx;
      w_word_idx_nxt = r_word_idx;
      if (w_pop && (r_state == ST_REQ)) begin
         w_byte_idx_nxt = {BW{1'b0}};
         w_word_idx_nxt = {WW{1'b0}};
      end else if (w_pop) begin
         w_byte_idx_nxt = {BW{1'b0}};
         w_word_idx_nxt = r_word_idx + 1'b1;
      end else if (w_advance) begin
         w_byte_idx_nxt = r_byte_idx + 1'b1;
      end else begin
         w_byte_idx_nxt = r_byte_idx;
      end
   end

   // Word storage; emptied by pointer reset only
   always_ff @(posedge DATA_O_CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= DATA_I;
      end
   end

   // FIFO pointers, occupancy, ready and sticky overflow
   always_ff @(posedge DATA_O_CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
         r_rdy    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_count <= w_cnt_nxt;
         r_rdy   <= (w_cnt_nxt < LP_DEPTH);
         r_ovf   <= r_ovf | (DATA_I_VLD & ~r_rdy);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Registered engine-side outputs and the MSB-first shift register
   always_ff @(posedge DATA_O_CLK or posedge RST) begin
      if (RST) begin
         r_tx_req   <= 1'b0;
         r_tx_len   <= 16'd0;
         r_vld      <= 1'b0;
         r_last     <= 1'b0;
         r_shift    <= {DATA_WIDTH{1'b0}};
         r_byte_idx <= {BW{1'b0}};
         r_word_idx <= {WW{1'b0}};
      end else begin
         r_tx_req   <= (w_state_nxt == ST_REQ);
         r_tx_len   <= (w_state_nxt == ST_REQ) ? LP_LEN : 16'd0;
         r_vld      <= (w_state_nxt == ST_SEND);
         r_last     <= (w_state_nxt == ST_SEND) && (w_byte_idx_nxt == LP_BYTE_LAST)
                       && (w_word_idx_nxt == LP_WORD_LAST);
         r_byte_idx <= w_byte_idx_nxt;
         r_word_idx <= w_word_idx_nxt;
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
         end else if (w_advance) begin
            r_shift <= r_shift << 4'd8;
         end
      end
   end

endmodule

// File: tb/tb_udp_tx_data_module.sv
// Scoreboard bench for udp_tx_data_module: accepted words are queued as bytes
// and compared against the byte stream, along with handshake and reset behaviour.
module tb_udp_tx_data_module;

   localparam int DW    = 72;
   localparam int BYTES = 9;
   localparam int WPP   = 16;
   localparam int DEPTH = 32;
   localparam int LEN   = WPP * BYTES;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_i = '0;
   logic          data_i_vld = 1'b0;
   logic          data_i_rdy;
   logic          tx_req;
   logic [15:0]   tx_len;
   logic          tx_ack = 1'b0;
   logic          tx_byte_rd = 1'b0;
   logic [7:0]    tx_byte;
   logic          tx_byte_vld;
   logic          tx_last;
   logic          overflow;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb_q[$];
   int         pkt_bytes = 0;
   int         pkts_done = 0;
   int         rd_bytes = 0;
   int         wr_words = 0;
   bit         stream_done = 1'b0;

   udp_tx_data_module #(.DATA_WIDTH(DW), .WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH)) dut (
      .DATA_O_CLK (clk),
      .RST        (rst),
      .DATA_I     (data_i),
      .DATA_I_VLD (data_i_vld),
      .DATA_I_RDY (data_i_rdy),
      .TX_REQ     (tx_req),
      .TX_LEN     (tx_len),
      .TX_ACK     (tx_ack),
      .TX_BYTE_RD (tx_byte_rd),
      .TX_BYTE    (tx_byte),
      .TX_BYTE_VLD(tx_byte_vld),
      .TX_LAST    (tx_last),
      .OVERFLOW   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input logic [DW-1:0] w, input bit acc);
      data_i     = w;
      data_i_vld = 1'b1;
      tick();
      data_i_vld = 1'b0;
      if (acc) begin
         for (int b = BYTES - 1; b >= 0; b--) sb_q.push_back(w[b*8 +: 8]);
         wr_words++;
      end
   endtask

   task automatic pulse_ack();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int t = 0;
      while (!tx_req && t < 3000) begin
         tick();
         t++;
      end
      chk(tag, 32'(tx_req), 32'd1);
      chk({tag, "_len"}, 32'(tx_len), 32'(LEN));
   endtask

   task automatic wait_pkts(input int target);
      int t = 0;
      while (pkts_done < target && t < 5000) begin
         tick();
         t++;
      end
      chk("pkt_done", 32'(pkts_done), 32'(target));
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   // Byte-stream monitor: every transfer is popped from the scoreboard
   always @(negedge clk) begin
      if (tx_byte_vld && tx_byte_rd) begin
         if (sb_q.size() == 0) chk("sb_unexpected", 32'(tx_byte), 32'hFFFF_FFFF);
         else                  chk("tx_byte", 32'(tx_byte), 32'(sb_q.pop_front()));
         chk("tx_last", 32'(tx_last), 32'(pkt_bytes == LEN - 1));
         rd_bytes++;
         if (pkt_bytes == LEN - 1) begin
            pkt_bytes = 0;
            pkts_done++;
         end else begin
            pkt_bytes++;
         end
      end
   end

   initial begin
      int bub;
      int base;
      int idle_bad;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", 32'(data_i_rdy), 32'd0);
      chk("rst_req", 32'(tx_req), 32'd0);
      chk("rst_len", 32'(tx_len), 32'd0);
      chk("rst_byte", 32'(tx_byte), 32'd0);
      chk("rst_vld", 32'(tx_byte_vld), 32'd0);
      chk("rst_last", 32'(tx_last), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();
      chk("rdy_after_rst", 32'(data_i_rdy), 32'd1);

      // 15 words must not request; the 16th must
      for (int i = 1; i <= 15; i++) put_word(DW'(i), 1'b1);
      repeat (4) tick();
      chk("req_15", 32'(tx_req), 32'd0);
      put_word(DW'(16), 1'b1);
      tick();
      chk("req_16", 32'(tx_req), 32'd1);
      chk("len_16", 32'(tx_len), 32'(LEN));

      // continuous read: no bubble across word boundaries
      tx_byte_rd = 1'b1;
      pulse_ack();
      chk("req_after_ack", 32'(tx_req), 32'd0);
      bub = 0;
      for (int i = 0; i < LEN; i++) begin
         if (!tx_byte_vld) bub++;
         tick();
      end
      chk("bubbles", 32'(bub), 32'd0);
      chk("gap_vld", 32'(tx_byte_vld), 32'd0);
      chk("gap_last", 32'(tx_last), 32'd0);
      chk("pkts_a", 32'(pkts_done), 32'd1);
      tx_byte_rd = 1'b0;

      // ack outside REQ is ignored
      repeat (2) tick();
      pulse_ack();
      tick();
      chk("ack_idle_vld", 32'(tx_byte_vld), 32'd0);
      chk("ack_idle_req", 32'(tx_req), 32'd0);

      // fill to depth, then overflow
      for (int i = 0; i < DEPTH; i++) put_word(rnd_word(), 1'b1);
      chk("full_rdy", 32'(data_i_rdy), 32'd0);
      chk("full_ovf", 32'(overflow), 32'd0);
      put_word(rnd_word(), 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_rdy", 32'(data_i_rdy), 32'd0);

      // three packets with random stalls and concurrent writes
      base = pkts_done;
      fork
         begin
            while (!stream_done) begin
               tx_byte_rd = 1'($urandom_range(1, 0));
               tick();
            end
            tx_byte_rd = 1'b0;
         end
         begin
            int k = 0;
            int g = 0;
            while (k < WPP && g < 5000) begin
               if ((wr_words - rd_bytes / BYTES) < DEPTH && $urandom_range(1, 0) == 1) begin
                  chk("rdy_w", 32'(data_i_rdy), 32'd1);
                  put_word(rnd_word(), 1'b1);
                  k++;
               end else begin
                  tick();
               end
               g++;
            end
         end
         begin
            for (int p = 0; p < 3; p++) begin
               wait_req("req_c");
               pulse_ack();
               wait_pkts(base + p + 1);
            end
            stream_done = 1'b1;
         end
      join
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      // reset in the middle of a packet
      repeat (3) tick();
      for (int i = 0; i < WPP; i++) put_word(rnd_word(), 1'b1);
      wait_req("req_d");
      tx_byte_rd = 1'b1;
      pulse_ack();
      begin
         int t = 0;
         while (pkt_bytes < 50 && t < 2000) begin
            tick();
            t++;
         end
      end
      chk("mid_bytes", 32'(pkt_bytes), 32'd50);
      rst        = 1'b1;
      tx_byte_rd = 1'b0;
      #1;
      chk("mid_vld", 32'(tx_byte_vld), 32'd0);
      chk("mid_req", 32'(tx_req), 32'd0);
      chk("mid_len", 32'(tx_len), 32'd0);
      chk("mid_byte", 32'(tx_byte), 32'd0);
      chk("mid_last", 32'(tx_last), 32'd0);
      chk("mid_ovf", 32'(overflow), 32'd0);
      chk("mid_rdy", 32'(data_i_rdy), 32'd0);
      sb_q.delete();
      pkt_bytes = 0;
      rd_bytes  = 0;
      wr_words  = 0;
      repeat (2) tick();
      rst        = 1'b0;
      tx_byte_rd = 1'b1;
      idle_bad   = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (tx_byte_vld || tx_req) idle_bad++;
      end
      chk("post_rst_idle", 32'(idle_bad), 32'd0);
      tx_byte_rd = 1'b0;

      base = pkts_done;
      for (int i = 0; i < WPP; i++) put_word(rnd_word(), 1'b1);
      wait_req("req_e");
      tx_byte_rd = 1'b1;
      pulse_ack();
      wait_pkts(base + 1);
      tx_byte_rd = 1'b0;
      chk("sb_final", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
